fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the 32-bit program counter and sequences it against a handshaking instruction memory and a stalling data memory. It replaces free-running PC advance with a state machine that:
- issues a fetch request,
- waits out instruction-memory busywait,
- presents one valid instruction per issue slot,
- holds PC and instruction while the data memory stalls,
- applies jump/branch redirects.

It sits between the instruction cache and the decode/control unit of the single-cycle 8-bit core.

---
 rtl/fetch_sequencer_pkg.sv | 10 +
 rtl/fetch_sequencer_next_pc_calc.sv | 21 ++
 rtl/fetch_sequencer.sv | 95 +++++++++
 tb/tb_fetch_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: state encoding, PC step and counter helpers shared by the fetch sequencer
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, FETCH, ISSUE, HOLD} fetch_state_t;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int CNT_W = 32;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + CNT_W'(1) : c;
    endfunction
endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// next_pc_calc: sequential or redirected successor of PC from jump/branch flags
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int OFFSET_W = 8
) (
    input  logic [31:0]         PC,
    input  logic                jump,
    input  logic                branch,
    input  logic                ZERO,
    input  logic [OFFSET_W-1:0] OFFSET,
    output logic [31:0]         next_pc,
    output logic                taken
);
    logic [31:0] disp;
    always_comb begin
        taken = jump | (branch & ZERO);
        disp = taken ? 32'(signed'(OFFSET)) << 2 : 32'd0;
        next_pc = PC + PC_STEP + disp;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/fetch FSM against busywait memories; FETCH_PERF_EN adds retire/stall counters
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          OFFSET_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IMEM_BUSYWAIT,
    input  logic [31:0]         IMEM_READDATA,
    input  logic                DMEM_BUSYWAIT,
    input  logic                jump,
    input  logic                branch,
    input  logic                ZERO,
    input  logic [OFFSET_W-1:0] OFFSET,
    output logic                IMEM_READ,
    output logic [31:0]         PC,
    output logic [31:0]         INSTRUCTION,
    output logic                INSTR_VALID,
`ifdef FETCH_PERF_EN
    output logic [CNT_W-1:0]    RETIRED_COUNT,
    output logic [CNT_W-1:0]    STALL_COUNT,
`endif
    output logic                STALL
);
    fetch_state_t state;
    logic [31:0] next_pc;
    logic taken;
    logic retire;

    next_pc_calc #(.OFFSET_W(OFFSET_W)) u_next_pc (
        .PC(PC),
        .jump(jump),
        .branch(branch),
        .ZERO(ZERO),
        .OFFSET(OFFSET),
        .next_pc(next_pc),
        .taken(taken)
    );

    assign retire = (state == ISSUE || state == HOLD) && !DMEM_BUSYWAIT;

    // Outputs are registered alongside the state so they always reflect the state being entered.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= BOOT;
            PC <= RESET_PC;
            INSTRUCTION <= '0;
            INSTR_VALID <= 1'b0;
            IMEM_READ <= 1'b0;
            STALL <= 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                    IMEM_READ <= 1'b1;
                end
                FETCH: if (!IMEM_BUSYWAIT) begin
                    state <= ISSUE;
                    INSTRUCTION <= IMEM_READDATA;
                    IMEM_READ <= 1'b0;
                    INSTR_VALID <= 1'b1;
                    STALL <= 1'b0;
                end
                ISSUE, HOLD: if (DMEM_BUSYWAIT) begin
                    state <= HOLD;
                    STALL <= 1'b1;
                end else begin
                    state <= FETCH;
                    PC <= taken ? next_pc : PC + PC_STEP;
                    IMEM_READ <= 1'b1;
                    INSTR_VALID <= 1'b0;
                    STALL <= 1'b1;
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RETIRED_COUNT <= '0;
            STALL_COUNT <= '0;
        end else begin
            RETIRED_COUNT <= sat_inc(RETIRED_COUNT, retire);
            STALL_COUNT <= sat_inc(STALL_COUNT, STALL);
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized self-checking bench with an instruction-level PC/timing model
module tb_fetch_sequencer;
    localparam logic [31:0] RPC = 32'h0000_0000;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic IMEM_BUSYWAIT = 1'b0;
    logic [31:0] IMEM_READDATA = '0;
    logic DMEM_BUSYWAIT = 1'b0;
    logic jump = 1'b0, branch = 1'b0, ZERO = 1'b0;
    logic [7:0] OFFSET = '0;
    logic IMEM_READ, INSTR_VALID, STALL;
    logic [31:0] PC, INSTRUCTION;
`ifdef FETCH_PERF_EN
    logic [31:0] RETIRED_COUNT, STALL_COUNT;
`endif
    int pass_cnt = 0, total = 0;
    logic [31:0] exp_pc = RPC;
    int exp_ret = 0, exp_stl = 0;

    fetch_sequencer #(.RESET_PC(RPC), .OFFSET_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_READDATA(IMEM_READDATA),
        .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .jump(jump), .branch(branch), .ZERO(ZERO), .OFFSET(OFFSET),
        .IMEM_READ(IMEM_READ), .PC(PC), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
`ifdef FETCH_PERF_EN
        .RETIRED_COUNT(RETIRED_COUNT), .STALL_COUNT(STALL_COUNT),
`endif
        .STALL(STALL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, total);
        $fatal(1);
    end

    // One clock: stl is the STALL level expected during the cycle being closed.
    task automatic step(input bit stl);
        exp_stl += int'(stl);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        #1;
        total++;
        if ({PC, INSTRUCTION, IMEM_READ, INSTR_VALID, STALL} !== {RPC, 32'h0, 3'b001})
            $display("FAIL reset_values: pc=%h instr=%h rd/vld/stl=%b%b%b want pc=%h instr=0 001",
                     PC, INSTRUCTION, IMEM_READ, INSTR_VALID, STALL, RPC);
        else pass_cnt++;
`ifdef FETCH_PERF_EN
        total++;
        if ({RETIRED_COUNT, STALL_COUNT} !== 64'h0)
            $display("FAIL reset_counters: retired=%0d stall=%0d want 0 0", RETIRED_COUNT, STALL_COUNT);
        else pass_cnt++;
`endif
        @(negedge CLK);
        RESET = 1'b1;
        exp_pc = RPC;
        exp_ret = 0;
        exp_stl = 0;
        total++;
        if ({PC, IMEM_READ, INSTR_VALID, STALL} !== {RPC, 3'b001})
            $display("FAIL boot_state: pc=%h rd/vld/stl=%b%b%b want pc=%h 001",
                     PC, IMEM_READ, INSTR_VALID, STALL, RPC);
        else pass_cnt++;
        step(1);
    endtask

    // Runs one instruction from FETCH through retirement; abort stops once HOLD is reached.
    task automatic run_instr(input int ib, input int db, input bit j, input bit b, input bit z,
                             input logic [7:0] off, input logic [31:0] word, input bit abort);
        int o;
        for (int k = 0; k <= ib; k++) begin
            total++;
            if ({PC, IMEM_READ, INSTR_VALID, STALL} !== {exp_pc, 3'b101})
                $display("FAIL fetch_phase: pc=%h rd/vld/stl=%b%b%b want pc=%h 101",
                         PC, IMEM_READ, INSTR_VALID, STALL, exp_pc);
            else pass_cnt++;
            IMEM_BUSYWAIT = (k < ib);
            IMEM_READDATA = (k < ib) ? $urandom : word;
            step(1);
        end
        IMEM_BUSYWAIT = 1'($urandom);
        IMEM_READDATA = $urandom;
        for (int h = 0; h <= db; h++) begin
            total++;
            if ({PC, INSTRUCTION, IMEM_READ, INSTR_VALID, STALL} !== {exp_pc, word, (h == 0) ? 3'b010 : 3'b011})
                $display("FAIL issue_phase: pc=%h instr=%h rd/vld/stl=%b%b%b want pc=%h instr=%h hold=%0d",
                         PC, INSTRUCTION, IMEM_READ, INSTR_VALID, STALL, exp_pc, word, h > 0);
            else pass_cnt++;
            if (abort && h == 1) return;
            DMEM_BUSYWAIT = (h < db);
            {jump, branch, ZERO} = (h < db) ? 3'($urandom) : {j, b, z};
            OFFSET = (h < db) ? 8'($urandom) : off;
            step(h != 0);
        end
        o = int'(off);
        if (o > 127) o -= 256;
        exp_pc = exp_pc + 32'(4 + ((j || (b && z)) ? o * 4 : 0));
        exp_ret++;
        {jump, branch, ZERO} = 3'($urandom);
        OFFSET = 8'($urandom);
        DMEM_BUSYWAIT = 1'($urandom);
`ifdef FETCH_PERF_EN
        total++;
        if (RETIRED_COUNT !== 32'(exp_ret) || STALL_COUNT !== 32'(exp_stl))
            $display("FAIL perf_counters: retired=%0d stall=%0d want %0d %0d",
                     RETIRED_COUNT, STALL_COUNT, exp_ret, exp_stl);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 2; i++) run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
    endtask

    task automatic test_imem_busy();
        run_instr(3, 0, 0, 0, 0, 8'h00, 32'hCAFE_0008, 0);
        run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
    endtask

    task automatic test_branch();
        run_instr(0, 0, 0, 1, 1, 8'hFE, $urandom, 0);
        run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
        run_instr(0, 0, 0, 1, 0, 8'hFE, $urandom, 0);
        run_instr(0, 0, 1, 1, 0, 8'h01, $urandom, 0);
        run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
    endtask

    task automatic test_hold_jump();
        do_reset();
        run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
        run_instr(0, 4, 1, 0, 0, 8'h03, 32'h1234_5678, 0);
        run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        run_instr(0, 0, 1, 0, 0, 8'h09, $urandom, 0);
        run_instr(1, 3, 0, 0, 0, 8'h00, $urandom, 1);
        #2;
        do_reset();
        run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        run_instr(0, 0, 1, 0, 0, 8'hFE, $urandom, 0);
        run_instr(0, 1, 0, 0, 0, 8'h00, $urandom, 0);
        run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++)
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                      1'($urandom), 1'($urandom), 8'($urandom), $urandom, 0);
        run_instr(0, 0, 0, 0, 0, 8'h00, $urandom, 0);
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_sequential();
        test_imem_busy();
        test_branch();
        test_hold_jump();
        test_reset_mid_hold();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
